// File: rtl/iomem_ram_arbiter_if.sv
// iomem-style request bus: one requester and one responder.
// The requester holds valid until it sees the one-cycle ready pulse.
interface iomem_ram_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iomem_ram_arbiter.sv
// Two-port arbiter in front of the single-port main RAM.
// Port 0 is the core iomem bus and port 1 is the loader/debug master.
// Arbitration is round-robin, and program mode grants port 1 only.
// A counter stretches every RAM access to LATENCY cycles from grant to ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate, latch the winner's request, decode the RAM window
// S_ISSUE | one-cycle RAM command (read enable or byte write strobes)
// S_WAIT  | capture read data on the first cycle, then count out latency
// S_RESP  | ready pulse and read data to the granted port
// S_ERR   | ready + bus_err pulse for an access outside the RAM window
module iomem_ram_arbiter #(
  parameter int unsigned LATENCY       = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff,
  parameter int unsigned RAM_DEPTH     = 131072
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  iomem_ram_arbiter_if.slave           m0,
  iomem_ram_arbiter_if.slave           m1,
  input  logic                         prog_mode_i,
  output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wr_data_o,
  output logic [3:0]                   mem_wr_strb_o,
  output logic                         mem_rd_en_o,
  input  logic [31:0]                  mem_rd_data_i,
  output logic                         bus_err_o,
  output logic                         busy_o
);

  localparam int ADDR_W = $clog2(RAM_DEPTH);
  // The counter is loaded with 2 in ISSUE. RESP therefore lands exactly
  // LATENCY cycles after the grant cycle.
  localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t      state_q;
  logic        rr_ptr_q;
  logic        port_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        ready0_q, ready1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        req0, req1, gnt_any, gnt_id, sel_hit;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [31:0] rd_word;

  assign m0.ready = ready0_q;
  assign m0.rdata = rdata0_q;
  assign m1.ready = ready1_q;
  assign m1.rdata = rdata1_q;

  // Arbitration: eligible requesters, round-robin tie-break, window decode
  always_comb begin
    req0    = m0.valid && !prog_mode_i;
    req1    = m1.valid;
    gnt_any = req0 || req1;
    if (req0 && req1) gnt_id = rr_ptr_q;
    else              gnt_id = req1;
    sel_addr  = gnt_id ? m1.addr  : m0.addr;
    sel_wdata = gnt_id ? m1.wdata : m0.wdata;
    sel_wstrb = gnt_id ? m1.wstrb : m0.wstrb;
    sel_hit   = (sel_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  end

  // With a 3-cycle latency the capture cycle is also the last WAIT cycle.
  // In that case the RAM word bypasses the register.
  assign rd_word = (cnt_q == 8'd2 && wstrb_q == 4'b0000) ? mem_rd_data_i : rdata_q;

  // Sequencer: state, latches and all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 1'b0;
      port_q        <= 1'b0;
      wstrb_q       <= 4'b0000;
      cnt_q         <= 8'd0;
      rdata_q       <= 32'd0;
      ready0_q      <= 1'b0;
      ready1_q      <= 1'b0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= 32'd0;
      mem_wr_strb_o <= 4'b0000;
      mem_rd_en_o   <= 1'b0;
      bus_err_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      ready0_q      <= 1'b0;
      ready1_q      <= 1'b0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= 32'd0;
      mem_wr_strb_o <= 4'b0000;
      mem_rd_en_o   <= 1'b0;
      bus_err_o     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            // The ISSUE-cycle command registers double as the request latch.
            // Later changes on the bus are therefore ignored.
            port_q  <= gnt_id;
            wstrb_q <= sel_wstrb;
            rdata_q <= 32'd0;
            busy_o  <= 1'b1;
            if (sel_hit) begin
              state_q       <= S_ISSUE;
              mem_addr_o    <= sel_addr[ADDR_W+1:2];
              mem_wr_data_o <= sel_wdata;
              mem_wr_strb_o <= sel_wstrb;
              mem_rd_en_o   <= (sel_wstrb == 4'b0000);
            end else begin
              state_q   <= S_ERR;
              bus_err_o <= 1'b1;
              if (gnt_id) ready1_q <= 1'b1;
              else        ready0_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= 8'd2;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'd2 && wstrb_q == 4'b0000) rdata_q <= mem_rd_data_i;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_RESP;
            if (port_q) begin
              ready1_q <= 1'b1;
              rdata1_q <= rd_word;
            end else begin
              ready0_q <= 1'b1;
              rdata0_q <= rd_word;
            end
          end
        end
        S_RESP, S_ERR: begin
          rr_ptr_q <= ~port_q;
          cnt_q    <= 8'd0;
          busy_o   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_ram_arbiter.sv
// Directed bench for iomem_ram_arbiter with a registered-read RAM model.
module tb_iomem_ram_arbiter;
  localparam int LAT   = 16;
  localparam int DEPTH = 131072;
  localparam int AW    = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iomem_ram_arbiter_if m0_bus ();
  iomem_ram_arbiter_if m1_bus ();

  logic          prog_mode;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_strb;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_data;
  logic          bus_err;
  logic          busy;

  iomem_ram_arbiter #(
    .LATENCY(LAT), .RAM_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .m0(m0_bus), .m1(m1_bus),
    .prog_mode_i(prog_mode), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_wr_strb_o(mem_wr_strb), .mem_rd_en_o(mem_rd_en), .mem_rd_data_i(mem_rd_data),
    .bus_err_o(bus_err), .busy_o(busy)
  );

  // Single-port RAM model: registered read, byte-enabled write
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) mem_rd_data <= 32'd0;
    else if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wr_strb[b]) ram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
  end

  // Event counters and invariant watch, sampled mid-cycle
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, viol = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;
  logic [3:0]  last_wr_strb = 0;
  always @(negedge clk) begin
    if (mem_rd_en) begin rd_cnt++; last_rd_addr = 32'(mem_addr); end
    if (mem_wr_strb != 4'b0000) begin
      wr_cnt++; last_wr_addr = 32'(mem_addr); last_wr_strb = mem_wr_strb; last_wr_data = mem_wr_data;
    end
    if (bus_err) err_cnt++;
    if ((!m0_bus.ready && m0_bus.rdata != 0) || (!m1_bus.ready && m1_bus.rdata != 0)) viol++;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on port p; k = cycles from grant to ready (0 = timeout)
  task automatic do_req(input bit p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output int k, output logic [31:0] rd, output logic err, output logic oth);
    @(negedge clk);
    if (p) begin m1_bus.addr = a; m1_bus.wdata = wd; m1_bus.wstrb = ws; m1_bus.valid = 1'b1; end
    else   begin m0_bus.addr = a; m0_bus.wdata = wd; m0_bus.wstrb = ws; m0_bus.valid = 1'b1; end
    k = 0; rd = 32'd0; err = 1'b0; oth = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (p ? m0_bus.ready : m1_bus.ready) oth = 1'b1;
      if (p ? m1_bus.ready : m0_bus.ready) begin
        k = i; rd = p ? m1_bus.rdata : m0_bus.rdata; err = bus_err;
        break;
      end
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
  endtask

  // Both ports request continuously; logs who got each ready pulse and when
  int          ev_port [8];
  int          ev_k    [8];
  logic [31:0] ev_rd   [8];
  task automatic run_pair(input bit pm, input int n, input int pm_clear_at, output int np);
    @(negedge clk);
    prog_mode = pm;
    m0_bus.addr = 32'h4000_0010; m0_bus.wstrb = 4'b0000; m0_bus.valid = 1'b1;
    m1_bus.addr = 32'h4000_0008; m1_bus.wstrb = 4'b0000; m1_bus.valid = 1'b1;
    np = 0;
    for (int i = 1; i <= 400 && np < n; i++) begin
      @(negedge clk);
      if (m0_bus.ready || m1_bus.ready) begin
        ev_port[np] = (m0_bus.ready && m1_bus.ready) ? 2 : (m1_bus.ready ? 1 : 0);
        ev_k[np]    = i;
        ev_rd[np]   = m1_bus.ready ? m1_bus.rdata : m0_bus.rdata;
        np++;
        if (np == pm_clear_at) prog_mode = 1'b0;
      end
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    prog_mode    = 1'b0;
  endtask

  int k, np, rc, wc, ec;
  logic [31:0] rd;
  logic err, oth, seen;

  initial begin
    prog_mode = 1'b0;
    m0_bus.valid = 1'b0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.wstrb = 0;
    m1_bus.valid = 1'b0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.wstrb = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ready", m0_bus.ready, 0);
    chk("rst_m1_ready", m1_bus.ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_strb", mem_wr_strb, 0);
    chk("rst_m0_rdata", m0_bus.rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mem_addr", 32'(mem_addr), 0);

    // Preload the words used below through the DUT
    do_req(0, 32'h4000_0010, 32'hCAFE_BABE, 4'hF, k, rd, err, oth);
    chk("pre0_lat", k, LAT);
    do_req(1, 32'h4000_0008, 32'hAABB_CCDD, 4'hF, k, rd, err, oth);
    chk("pre1_lat", k, LAT);

    // Port 0 read of word 4
    rc = rd_cnt;
    do_req(0, 32'h4000_0010, 32'd0, 4'h0, k, rd, err, oth);
    chk("rd_lat", k, LAT);
    chk("rd_data", rd, 32'hCAFE_BABE);
    chk("rd_err", err, 0);
    chk("rd_other_ready", oth, 0);
    chk("rd_en_pulses", rc == rd_cnt ? 0 : rd_cnt - rc, 1);
    chk("rd_addr", last_rd_addr, 4);
    @(negedge clk);
    chk("rd_data_after", m0_bus.rdata, 0);
    chk("rd_ready_after", m0_bus.ready, 0);

    // Port 1 partial write of word 2
    rc = rd_cnt; wc = wr_cnt;
    do_req(1, 32'h4000_0008, 32'h1122_3344, 4'b0101, k, rd, err, oth);
    chk("wr_lat", k, LAT);
    chk("wr_rdata", rd, 0);
    chk("wr_pulses", wr_cnt - wc, 1);
    chk("wr_strb", last_wr_strb, 4'b0101);
    chk("wr_addr", last_wr_addr, 2);
    chk("wr_data", last_wr_data, 32'h1122_3344);
    chk("wr_no_rd", rd_cnt - rc, 0);
    do_req(0, 32'h4000_0008, 32'd0, 4'h0, k, rd, err, oth);
    chk("wr_readback", rd, 32'hAA22_CC44);

    // Address bit 19 is inside the window but above the RAM address, so it aliases to word 4
    do_req(1, 32'h4008_0010, 32'd0, 4'h0, k, rd, err, oth);
    chk("alias_data", rd, 32'hCAFE_BABE);

    // Out-of-window access
    rc = rd_cnt; ec = err_cnt;
    do_req(0, 32'h2000_0000, 32'd0, 4'h0, k, rd, err, oth);
    chk("err_lat", k, 1);
    chk("err_flag", err, 1);
    chk("err_rdata", rd, 0);
    @(negedge clk);
    chk("err_no_rd", rd_cnt - rc, 0);
    chk("err_pulses", err_cnt - ec, 1);

    // Round-robin from reset
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    run_pair(1'b0, 4, -1, np);
    chk("rr_events", np, 4);
    chk("rr_p0", ev_port[0], 0); chk("rr_k0", ev_k[0], LAT);
    chk("rr_p1", ev_port[1], 1); chk("rr_k1", ev_k[1], 2*LAT+1);
    chk("rr_p2", ev_port[2], 0); chk("rr_k2", ev_k[2], 3*LAT+2);
    chk("rr_p3", ev_port[3], 1); chk("rr_k3", ev_k[3], 4*LAT+3);
    chk("rr_rd0", ev_rd[0], 32'hCAFE_BABE);
    chk("rr_rd1", ev_rd[1], 32'hAA22_CC44);

    // Program mode serves port 1 only, then port 0 once it drops
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    run_pair(1'b1, 3, 2, np);
    chk("pm_events", np, 3);
    chk("pm_p0", ev_port[0], 1); chk("pm_k0", ev_k[0], LAT);
    chk("pm_p1", ev_port[1], 1); chk("pm_k1", ev_k[1], 2*LAT+1);
    chk("pm_p2", ev_port[2], 0); chk("pm_k2", ev_k[2], 3*LAT+2);

    // Reset during WAIT aborts the read without a ready pulse
    @(negedge clk);
    m0_bus.addr = 32'h4000_0010; m0_bus.wstrb = 4'b0000; m0_bus.valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_async", busy, 0);
    chk("abort_ready_async", m0_bus.ready, 0);
    m0_bus.valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m0_bus.ready || m1_bus.ready) seen = 1'b1;
    end
    chk("abort_no_ready", seen, 0);
    rst_n = 1'b1;
    run_pair(1'b0, 1, -1, np);
    chk("abort_next_events", np, 1);
    chk("abort_next_port", ev_port[0], 0);
    chk("abort_next_lat", ev_k[0], LAT);
    chk("abort_next_rd", ev_rd[0], 32'hCAFE_BABE);

    chk("rdata_without_ready", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
